// File: rtl/magnitude_comparator_seq.sv
// Bit-serial magnitude comparator: scans operands MSB-first, one bit per clock,
// stopping at the first differing bit. Supports unsigned or two's-complement operands.
module magnitude_comparator_seq #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             bit_a;
  logic             bit_b;
  logic             sign_bit;

  // In a signed compare the MSB carries negative weight, so its polarity is reversed.
  always_comb begin
    bit_a    = a_q[idx];
    bit_b    = b_q[idx];
    sign_bit = (SIGNED != 1'b0) && (idx == IW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IW'(WIDTH - 1);
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (bit_a != bit_b) begin
            gt    <= sign_bit ? bit_b : bit_a;
            lt    <= sign_bit ? bit_a : bit_b;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// Scoreboard bench for magnitude_comparator_seq: three instances cover the
// 2-bit unsigned, 8-bit unsigned and 8-bit signed configurations.
module tb_magnitude_comparator_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [3];
  logic [7:0] a_s     [3];
  logic [7:0] b_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       gt_s    [3];
  logic       lt_s    [3];
  logic       eq_s    [3];
  logic       prev_done [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb [3][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  magnitude_comparator_seq #(.WIDTH(2), .SIGNED(1'b0)) u_w2u (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0][1:0]), .b(b_s[0][1:0]),
    .busy(busy_s[0]), .done(done_s[0]), .gt(gt_s[0]), .lt(lt_s[0]), .eq(eq_s[0]));

  magnitude_comparator_seq #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .gt(gt_s[1]), .lt(lt_s[1]), .eq(eq_s[1]));

  magnitude_comparator_seq #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .gt(gt_s[2]), .lt(lt_s[2]), .eq(eq_s[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 2 : 8;
  endfunction

  function automatic bit sgn(input int k);
    return (k == 2);
  endfunction

  function automatic exp_t model(input int k, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   w  = wid(k);
    int   xi = int'(x) & ((1 << w) - 1);
    int   yi = int'(y) & ((1 << w) - 1);
    int   p  = -1;
    if (sgn(k) && x[w-1]) xi -= (1 << w);
    if (sgn(k) && y[w-1]) yi -= (1 << w);
    for (int i = w - 1; i >= 0; i--)
      if (p < 0 && x[i] != y[i]) p = i;
    e.res = {xi > yi, xi < yi, xi == yi};
    e.lat = (p < 0) ? w : w - p;
    e.acc = 0;
    return e;
  endfunction

  // Monitor: pop and compare on each done pulse
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_s[k]) begin
        check($sformatf("u%0d_done_width", k), 32'(prev_done[k]), 32'd0);
        if (sb[k].size() == 0) begin
          check($sformatf("u%0d_spurious_done", k), 32'(done_s[k]), 32'd0);
        end else begin
          mon_e = sb[k].pop_front();
          check($sformatf("u%0d_result", k), 32'({gt_s[k], lt_s[k], eq_s[k]}), 32'(mon_e.res));
          check($sformatf("u%0d_latency", k), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
      prev_done[k] = done_s[k];
    end
  end

  task automatic wait_empty(input int k);
    for (int i = 0; i < 40 && sb[k].size() != 0; i++) @(negedge clk);
    if (sb[k].size() != 0) begin
      check($sformatf("u%0d_timeout", k), 32'(sb[k].size()), 32'd0);
      sb[k].delete();
    end
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 40 && busy_s[k]; i++) @(negedge clk);
  endtask

  task automatic run(input int k, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    wait_idle(k);
    start_s[k] = 1'b1;
    a_s[k]     = x;
    b_s[k]     = y;
    @(negedge clk);
    start_s[k] = 1'b0;
    a_s[k]     = 8'($urandom);
    b_s[k]     = 8'($urandom);
    e     = model(k, x, y);
    e.acc = cyc;
    sb[k].push_back(e);
    check($sformatf("u%0d_busy_after_accept", k), 32'(busy_s[k]), 32'd1);
    wait_empty(k);
  endtask

  initial begin
    exp_t e;
    bit   seen;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k]   = 1'b0;
      a_s[k]       = '0;
      b_s[k]       = '0;
      prev_done[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("u%0d_reset_state", k),
            32'({busy_s[k], done_s[k], gt_s[k], lt_s[k], eq_s[k]}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2-bit unsigned truth table
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        run(0, 8'(x), 8'(y));

    // 8-bit unsigned: MSB difference, LSB difference, equal with hold
    run(1, 8'h80, 8'h7F);
    run(1, 8'h34, 8'h35);
    run(1, 8'hA5, 8'hA5);
    repeat (5) begin
      @(negedge clk);
      check("eq_hold", 32'({gt_s[1], lt_s[1], eq_s[1]}), 32'b001);
    end

    // 8-bit signed: sign-bit polarity and deep scan of negatives
    run(2, 8'hFF, 8'h01);
    run(2, 8'h80, 8'h81);
    run(2, 8'h01, 8'hFF);
    run(2, 8'h7F, 8'h80);

    // start held high, operands disturbed mid-scan, back-to-back accept on done
    wait_idle(1);
    start_s[1] = 1'b1;
    a_s[1]     = 8'h10;
    b_s[1]     = 8'h00;
    @(negedge clk);
    e     = model(1, 8'h10, 8'h00);
    e.acc = cyc;
    sb[1].push_back(e);
    a_s[1] = 8'($urandom);
    b_s[1] = 8'($urandom);
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_s[1]) seen = 1'b1;
      else begin
        a_s[1] = 8'($urandom);
        b_s[1] = 8'($urandom);
      end
    end
    check("t5_done_seen", 32'(seen), 32'd1);
    a_s[1] = 8'h00;
    b_s[1] = 8'hFF;
    @(negedge clk);
    e     = model(1, 8'h00, 8'hFF);
    e.acc = cyc;
    sb[1].push_back(e);
    check("b2b_busy", 32'(busy_s[1]), 32'd1);
    check("b2b_done_drop", 32'(done_s[1]), 32'd0);
    check("b2b_result_clear", 32'({gt_s[1], lt_s[1], eq_s[1]}), 32'd0);
    start_s[1] = 1'b0;
    wait_empty(1);

    // reset aborts an equal compare three cycles in
    wait_idle(1);
    start_s[1] = 1'b1;
    a_s[1]     = 8'h5A;
    b_s[1]     = 8'h5A;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_abort", 32'({busy_s[1], done_s[1], gt_s[1], lt_s[1], eq_s[1]}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done_s[1]), 32'd0);
    end
    run(1, 8'h5A, 8'h5A);
    run(1, 8'h3C, 8'hC3);

    // random pairs on both 8-bit configurations
    for (int i = 0; i < 12; i++) begin
      run(1, 8'($urandom), 8'($urandom));
      run(2, 8'($urandom), 8'($urandom));
    end
    run(2, 8'h9C, 8'h9C);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
